// File: rtl/alu_decoder_pkg.sv
// Shared ALU control codes, ALUOp classes, funct3 constants and the
// registered control payload for the RV32I second-level ALU decoder.
package alu_decoder_pkg;

  localparam int unsigned ALU_CODE_W = 3;
  localparam int unsigned F3_W       = 3;

  typedef logic [ALU_CODE_W-1:0] alu_code_t;

  localparam alu_code_t ALU_ADD = 3'b000;
  localparam alu_code_t ALU_SUB = 3'b001;
  localparam alu_code_t ALU_AND = 3'b010;
  localparam alu_code_t ALU_OR  = 3'b011;
  localparam alu_code_t ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_e;

  localparam logic [F3_W-1:0] F3_ADD = 3'b000;
  localparam logic [F3_W-1:0] F3_SLT = 3'b010;
  localparam logic [F3_W-1:0] F3_OR  = 3'b110;
  localparam logic [F3_W-1:0] F3_AND = 3'b111;

  // Payload carried across the ID/EX boundary.
  typedef struct packed {
    logic      illegal;
    alu_code_t ctrl;
  } alu_ctrl_t;

endpackage

// File: rtl/alu_ctrl_reg.sv
// ID/EX register for the decoded ALU control: sync active-low reset,
// flush (bubble = ADD, legal) over enable, enable low holds.
module alu_ctrl_reg
  import alu_decoder_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      en_i,
  input  logic      flush_i,
  input  alu_ctrl_t d_i,
  output alu_ctrl_t q_o
);

  alu_ctrl_t ctrl_q;
  alu_ctrl_t ctrl_d;

  always_comb begin
    ctrl_d = ctrl_q;
    if (flush_i) begin
      ctrl_d = '0;
    end else if (en_i) begin
      ctrl_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign q_o = ctrl_q;

endmodule

// File: rtl/alu_decoder.sv
// RV32I second-level ALU control decoder: combinational ALUOp/funct3/funct7[5]
// decode plus a stall/flush-controlled registered copy for ID/EX.
module alu_decoder
  import alu_decoder_pkg::*;
#(
  parameter int unsigned CTRL_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        ALUOp,
  input  logic              funct7b5,
  input  logic [2:0]        funct3,
  input  logic              en,
  input  logic              flush,
  output logic [CTRL_W-1:0] ALUControl,
  output logic              illegal,
  output logic [CTRL_W-1:0] ALUControl_q,
  output logic              illegal_q
);

  alu_code_t ctrl_c;
  logic      illegal_c;
  alu_ctrl_t dec_c;
  alu_ctrl_t reg_q;

  // Decode; every input combination lands on a defined code.
  always_comb begin
    ctrl_c    = ALU_ADD;
    illegal_c = 1'b0;
    case (ALUOp)
      ALUOP_ADD: ctrl_c = ALU_ADD;
      ALUOP_SUB: ctrl_c = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          F3_ADD:  ctrl_c = funct7b5 ? ALU_SUB : ALU_ADD;
          F3_SLT:  ctrl_c = ALU_SLT;
          F3_OR:   ctrl_c = ALU_OR;
          F3_AND:  ctrl_c = ALU_AND;
          default: begin
            ctrl_c    = ALU_ADD;
            illegal_c = 1'b1;
          end
        endcase
      end
      ALUOP_RSVD: begin
        ctrl_c    = ALU_ADD;
        illegal_c = 1'b1;
      end
      default: begin
        ctrl_c    = ALU_ADD;
        illegal_c = 1'b1;
      end
    endcase
  end

  assign ALUControl    = CTRL_W'(ctrl_c);
  assign illegal       = illegal_c;
  assign dec_c.ctrl    = ctrl_c;
  assign dec_c.illegal = illegal_c;

  alu_ctrl_reg u_ctrl_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (en),
    .flush_i (flush),
    .d_i     (dec_c),
    .q_o     (reg_q)
  );

  assign ALUControl_q = CTRL_W'(reg_q.ctrl);
  assign illegal_q    = reg_q.illegal;

endmodule

// File: tb/tb_alu_decoder.sv
// Self-checking bench for alu_decoder: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_alu_decoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] ALUOp;
  logic       funct7b5;
  logic [2:0] funct3;
  logic       en;
  logic       flush;
  logic [2:0] ALUControl;
  logic       illegal;
  logic [2:0] ALUControl_q;
  logic       illegal_q;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [3:0] exp_q = 4'b0000;
  logic       model_live = 1'b0;

  alu_decoder #(.CTRL_W(3)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ALUOp        (ALUOp),
    .funct7b5     (funct7b5),
    .funct3       (funct3),
    .en           (en),
    .flush        (flush),
    .ALUControl   (ALUControl),
    .illegal      (illegal),
    .ALUControl_q (ALUControl_q),
    .illegal_q    (illegal_q)
  );

  always #5 clk = ~clk;

  // Expected {illegal, code} from the instruction-level rules.
  function automatic logic [3:0] model(input logic [1:0] op, input logic f7,
                                       input logic [2:0] f3);
    if (op == 2'b00) return 4'b0_000;
    if (op == 2'b01) return 4'b0_001;
    if (op == 2'b11) return 4'b1_000;
    if (f3 == 3'b000) return f7 ? 4'b0_001 : 4'b0_000;
    if (f3 == 3'b010) return 4'b0_101;
    if (f3 == 3'b110) return 4'b0_011;
    if (f3 == 3'b111) return 4'b0_010;
    return 4'b1_000;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %b, expected %b", name, act, req);
  endtask

  // Registered-path model: reset, then flush, then enable, else hold.
  always @(posedge clk) begin
    if (reset_n === 1'b0) begin
      exp_q      <= 4'b0000;
      model_live <= 1'b1;
    end else if (flush) exp_q <= 4'b0000;
    else if (en)        exp_q <= model(ALUOp, funct7b5, funct3);
  end

  // Per-cycle comparison away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      check("comb", {illegal, ALUControl}, model(ALUOp, funct7b5, funct3));
      check("reg", {illegal_q, ALUControl_q}, exp_q);
    end
  end

  typedef struct {
    logic [1:0] op;
    logic       f7;
    logic [2:0] f3;
    logic [3:0] req;
  } vec_t;

  vec_t vecs[15] = '{
    '{2'b00, 1'b0, 3'b000, 4'b0_000},
    '{2'b01, 1'b0, 3'b000, 4'b0_001},
    '{2'b10, 1'b0, 3'b000, 4'b0_000},
    '{2'b10, 1'b1, 3'b000, 4'b0_001},
    '{2'b10, 1'b0, 3'b010, 4'b0_101},
    '{2'b10, 1'b0, 3'b110, 4'b0_011},
    '{2'b10, 1'b0, 3'b111, 4'b0_010},
    '{2'b10, 1'b1, 3'b010, 4'b0_101},
    '{2'b10, 1'b1, 3'b110, 4'b0_011},
    '{2'b10, 1'b1, 3'b111, 4'b0_010},
    '{2'b10, 1'b0, 3'b001, 4'b1_000},
    '{2'b10, 1'b1, 3'b101, 4'b1_000},
    '{2'b11, 1'b1, 3'b111, 4'b1_000},
    '{2'b00, 1'b1, 3'b101, 4'b0_000},
    '{2'b01, 1'b1, 3'b011, 4'b0_001}
  };

  task automatic drive(input logic [1:0] op, input logic f7, input logic [2:0] f3);
    ALUOp    = op;
    funct7b5 = f7;
    funct3   = f3;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    en      = 1'b0;
    flush   = 1'b0;
    drive(2'b00, 1'b0, 3'b000);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("reset_q", {illegal_q, ALUControl_q}, 4'b0_000);

    next_cycle();
    reset_n = 1'b1;
    en      = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].f7, vecs[i].f3);
      @(negedge clk);
      check($sformatf("vec%0d", i), {illegal, ALUControl}, vecs[i].req);
      next_cycle();
    end

    // Exhaustive sweep with mixed stall/flush; X/Z screen on every output.
    for (int i = 0; i < 64; i++) begin
      logic [5:0] v;
      v = 6'(i);
      drive(v[5:4], v[3], v[2:0]);
      en    = 1'($urandom_range(0, 1));
      flush = ((i % 11) == 5);
      @(negedge clk);
      check("no_xz", {3'b000, $isunknown({ALUControl, illegal, ALUControl_q, illegal_q})}, 4'b0000);
      next_cycle();
    end
    flush = 1'b0;

    // Load OR, then stall with changed inputs.
    en = 1'b1;
    drive(2'b10, 1'b0, 3'b110);
    next_cycle();
    @(negedge clk);
    check("load_or", {illegal_q, ALUControl_q}, 4'b0_011);
    next_cycle();
    en = 1'b0;
    drive(2'b10, 1'b0, 3'b010);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("stall_hold", {illegal_q, ALUControl_q}, 4'b0_011);

    // Load an illegal code, then flush while stalled.
    next_cycle();
    en = 1'b1;
    drive(2'b11, 1'b0, 3'b000);
    next_cycle();
    @(negedge clk);
    check("load_illegal", {illegal_q, ALUControl_q}, 4'b1_000);
    next_cycle();
    en    = 1'b0;
    flush = 1'b1;
    next_cycle();
    @(negedge clk);
    check("flush_over_stall", {illegal_q, ALUControl_q}, 4'b0_000);

    // Load SLT, then reset with a pending SLT load.
    next_cycle();
    flush = 1'b0;
    en    = 1'b1;
    drive(2'b10, 1'b1, 3'b010);
    next_cycle();
    @(negedge clk);
    check("load_slt", {illegal_q, ALUControl_q}, 4'b0_101);
    next_cycle();
    drive(2'b10, 1'b0, 3'b111);
    reset_n = 1'b0;
    next_cycle();
    @(negedge clk);
    check("reset_over_load", {illegal_q, ALUControl_q}, 4'b0_000);
    next_cycle();
    reset_n = 1'b1;
    next_cycle();
    @(negedge clk);
    check("after_reset_and", {illegal_q, ALUControl_q}, 4'b0_010);

    next_cycle();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
